// File: rtl/conv_mesh_feeder.sv
// conv_mesh_feeder: assembles a column-major pixel stream into column words
// for the conv_mesh west edge, using ping-pong column buffers.
module conv_mesh_feeder #(
  parameter int DW   = 8,
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int CW   = $clog2(COLS)
) (
  input  logic                 ck,
  input  logic                 res,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROWS*DW-1:0]   out_col,
  output logic [CW-1:0]        out_col_idx,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 frame_done,
  output logic                 err_sof
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [1:0][ROWS*DW-1:0] col_q;
  logic [1:0][CW-1:0]      idx_q;
  logic [1:0]              first_q;
  logic [1:0]              last_q;
  logic [1:0]              full_q;

  logic [RW-1:0] row_cnt;
  logic [CW-1:0] in_col;
  logic          fill_sel;
  logic          send_sel;

  logic          acc;
  logic          sof_bad;
  logic          wrap;
  logic          hs;
  logic [RW-1:0] row_eff;
  logic [CW-1:0] col_eff;

  always_comb begin
    in_ready = res & ~full_q[fill_sel];
    acc      = in_valid & in_ready;
    // a misplaced sof restarts the frame on the pixel that carries it
    sof_bad  = acc & in_sof & ((row_cnt != '0) | (in_col != '0));
    row_eff  = sof_bad ? '0 : row_cnt;
    col_eff  = sof_bad ? '0 : in_col;
    wrap     = acc & (row_eff == RW'(ROWS-1));
  end

  always_comb begin
    out_valid   = full_q[send_sel];
    out_col     = out_valid ? col_q[send_sel] : '0;
    out_col_idx = out_valid ? idx_q[send_sel] : '0;
    out_first   = out_valid & first_q[send_sel];
    out_last    = out_valid & last_q[send_sel];
    hs          = out_valid & out_ready;
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      col_q      <= '0;
      idx_q      <= '0;
      first_q    <= '0;
      last_q     <= '0;
      full_q     <= '0;
      row_cnt    <= '0;
      in_col     <= '0;
      fill_sel   <= 1'b0;
      send_sel   <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      if (acc) begin
        col_q[fill_sel][int'(row_eff)*DW +: DW] <= in_data;
        if (wrap) begin
          full_q[fill_sel]  <= 1'b1;
          idx_q[fill_sel]   <= col_eff;
          first_q[fill_sel] <= (col_eff == '0);
          last_q[fill_sel]  <= (col_eff == CW'(COLS-1));
          fill_sel          <= ~fill_sel;
          row_cnt           <= '0;
          if (col_eff == CW'(COLS-1))
            in_col <= '0;
          else
            in_col <= col_eff + 1'b1;
        end else begin
          row_cnt <= row_eff + 1'b1;
          in_col  <= col_eff;
        end
      end
      // fill and send never touch the same buffer in one cycle
      if (hs) begin
        full_q[send_sel] <= 1'b0;
        send_sel         <= ~send_sel;
      end
      frame_done <= hs & last_q[send_sel];
      err_sof    <= sof_bad;
    end
  end

endmodule

// File: tb/tb_conv_mesh_feeder.sv
// tb_conv_mesh_feeder: directed bench for conv_mesh_feeder with a
// column scoreboard driven by output handshakes.
module tb_conv_mesh_feeder;

  localparam int DW   = 8;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CW   = 3;
  localparam int W    = ROWS*DW;

  logic          ck;
  logic          res;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_col;
  logic [CW-1:0] out_col_idx;
  logic          out_first;
  logic          out_last;
  logic          frame_done;
  logic          err_sof;

  conv_mesh_feeder #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .CW(CW)
  ) dut (
    .ck(ck),
    .res(res),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_sof(in_sof),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_col(out_col),
    .out_col_idx(out_col_idx),
    .out_first(out_first),
    .out_last(out_last),
    .frame_done(frame_done),
    .err_sof(err_sof)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [W-1:0] col;
    int           idx;
    bit           first;
    bit           last;
  } exp_t;

  exp_t q[$];
  int   n_run;
  int   n_fail;
  int   fd_cnt;
  int   err_cnt;
  int   stalls;
  bit   mon_on;
  bit   fd_due;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mkcol(input int base);
    logic [W-1:0] c;
    c = '0;
    for (int r = 0; r < ROWS; r++)
      c[r*DW +: DW] = DW'(base + r);
    return c;
  endfunction

  task automatic push_exp(input int base, input int idx,
                          input bit first, input bit last);
    exp_t e;
    e.col   = mkcol(base);
    e.idx   = idx;
    e.first = first;
    e.last  = last;
    q.push_back(e);
  endtask

  always @(negedge ck) begin
    if (mon_on) begin
      if (fd_due) begin
        chk("frame_done", W'(frame_done), W'(1));
        fd_due = 1'b0;
      end
      if (frame_done) fd_cnt++;
      if (err_sof) err_cnt++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_col", W'(1), W'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("col", out_col, e.col);
          chk("idx", W'(out_col_idx), W'(e.idx));
          chk("first", W'(out_first), W'(e.first));
          chk("last", W'(out_last), W'(e.last));
          if (e.last) fd_due = 1'b1;
        end
      end
    end
  end

  task automatic send_pix(input logic [DW-1:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (in_ready) begin
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        return;
      end
      stalls++;
      @(posedge ck);
      #1;
    end
    chk("accept_timeout", W'(0), W'(1));
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    mon_on   = 1'b0;
    fd_due   = 1'b0;
    q.delete();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    res      = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    res = 1'b1;
    @(posedge ck);
    #1;
  endtask

  initial begin
    int nacc;
    int d;
    bit a;
    n_run = 0; n_fail = 0; fd_cnt = 0; err_cnt = 0; stalls = 0;
    mon_on = 1'b0; fd_due = 1'b0;
    res = 1'b0; in_valid = 1'b1; in_data = 8'hAA; in_sof = 1'b0;
    out_ready = 1'b0;

    // reset with input offered
    repeat (3) @(posedge ck);
    #1;
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_out_col", out_col, W'(0));
    chk("rst_idx", W'(out_col_idx), W'(0));
    chk("rst_first", W'(out_first), W'(0));
    chk("rst_last", W'(out_last), W'(0));
    chk("rst_frame_done", W'(frame_done), W'(0));
    chk("rst_err_sof", W'(err_sof), W'(0));
    in_valid = 1'b0;
    res = 1'b1;
    @(posedge ck);
    #1;
    chk("rel_in_ready", W'(in_ready), W'(1));
    repeat (2) @(posedge ck);
    #1;
    chk("rel_out_valid", W'(out_valid), W'(0));

    // single column
    out_ready = 1'b1;
    for (int p = 1; p <= 8; p++) send_pix(DW'(p), 1'b0);
    chk("one_valid", W'(out_valid), W'(1));
    chk("one_col", out_col, mkcol(1));
    chk("one_idx", W'(out_col_idx), W'(0));
    chk("one_first", W'(out_first), W'(1));
    chk("one_last", W'(out_last), W'(0));
    @(posedge ck);
    #1;
    chk("one_hs_drop", W'(out_valid), W'(0));

    // backpressure: frame continues at column 1
    out_ready = 1'b0;
    nacc = 0;
    d = 1;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_data = DW'(d);
      @(negedge ck);
      a = in_ready;
      @(posedge ck);
      #1;
      if (a) begin
        nacc++;
        d++;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepts", W'(nacc), W'(16));
    chk("bp_in_ready", W'(in_ready), W'(0));
    chk("bp_hold_col", out_col, mkcol(1));
    chk("bp_hold_idx", W'(out_col_idx), W'(1));
    out_ready = 1'b1;
    @(posedge ck);
    #1;
    chk("bp_col2", out_col, mkcol(9));
    chk("bp_idx2", W'(out_col_idx), W'(2));
    chk("bp_ready_back", W'(in_ready), W'(1));
    @(posedge ck);
    #1;
    chk("bp_drained", W'(out_valid), W'(0));

    // full frame plus first column of the next frame
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(8*k, k, k == 0, k == 7);
    push_exp(100, 0, 1'b1, 1'b0);
    fd_cnt = 0; stalls = 0;
    mon_on = 1'b1;
    for (int p = 0; p < 64; p++) send_pix(DW'(p), 1'b0);
    for (int p = 100; p < 108; p++) send_pix(DW'(p), 1'b0);
    repeat (4) @(posedge ck);
    #1;
    chk("ff_stalls", W'(stalls), W'(0));
    chk("ff_fd_count", W'(fd_cnt), W'(1));
    chk("ff_all_out", W'(q.size()), W'(0));

    // misplaced sof on row 3 of column 2
    do_reset();
    out_ready = 1'b1;
    push_exp(1, 0, 1'b1, 1'b0);
    push_exp(9, 1, 1'b0, 1'b0);
    push_exp(200, 0, 1'b1, 1'b0);
    err_cnt = 0; fd_cnt = 0;
    mon_on = 1'b1;
    for (int p = 1; p <= 19; p++) send_pix(DW'(p), 1'b0);
    send_pix(8'd200, 1'b1);
    chk("sof_err_pulse", W'(err_sof), W'(1));
    send_pix(8'd201, 1'b0);
    chk("sof_err_low", W'(err_sof), W'(0));
    for (int p = 202; p <= 207; p++) send_pix(DW'(p), 1'b0);
    repeat (4) @(posedge ck);
    #1;
    chk("sof_all_out", W'(q.size()), W'(0));
    chk("sof_err_count", W'(err_cnt), W'(1));
    chk("sof_no_fd", W'(fd_cnt), W'(0));

    // reset with both buffers full
    do_reset();
    out_ready = 1'b0;
    for (int p = 1; p <= 16; p++) send_pix(DW'(p), 1'b0);
    chk("mr_full_valid", W'(out_valid), W'(1));
    chk("mr_full_ready", W'(in_ready), W'(0));
    #2;
    res = 1'b0;
    #1;
    chk("mr_valid_drop", W'(out_valid), W'(0));
    chk("mr_in_ready", W'(in_ready), W'(0));
    chk("mr_col_zero", out_col, W'(0));
    @(posedge ck);
    #1;
    res = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge ck);
    #1;
    chk("mr_no_stale", W'(out_valid), W'(0));
    push_exp(50, 0, 1'b1, 1'b0);
    mon_on = 1'b1;
    for (int p = 50; p < 58; p++) send_pix(DW'(p), 1'b0);
    repeat (3) @(posedge ck);
    #1;
    chk("mr_all_out", W'(q.size()), W'(0));

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
